// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct fields, ALU control codes and the internal alu_op class.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's alu_op class and the R-type funct field to the ALU
// control code. Unknown funct values fall back to add.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int ALUC_W = 3
) (
  input  alu_op_t           alu_op,
  input  logic [OP_W-1:0]   funct,
  output logic [ALUC_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALU_OP_SUB: alu_control = ALUC_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_control = ALUC_ADD;
          FUNCT_SUB: alu_control = ALUC_SUB;
          FUNCT_AND: alu_control = ALUC_AND;
          FUNCT_OR:  alu_control = ALUC_OR;
          FUNCT_SLT: alu_control = ALUC_SLT;
          default:   alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore main controller for the multicycle MIPS datapath: sequences each
// instruction over 3-5 states and drives the datapath selects and enables.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUC_W  = 3,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic [ALUC_W-1:0]  alu_control,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t  state_q, state_d;
  alu_op_t alu_op;
  logic    pc_write_s, branch_s, ir_write_s, reg_write_s, mem_write_s;
  logic    instr_done_s, illegal_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = FETCH;
    iord         = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_src       = 2'b00;
    alu_op       = ALU_OP_ADD;
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b01;
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here so BRANCH can load it from ALUOut.
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d   = FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        mem_to_reg   = 1'b1;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        mem_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_dst      = 1'b1;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = ALU_OP_SUB;
        pc_src       = 2'b01;
        branch_s     = 1'b1;
        instr_done_s = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      JUMP: begin
        pc_src       = 2'b10;
        pc_write_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Enables are masked during reset so the FETCH state held in reset has no effect.
  assign ir_write   = rst_n & ir_write_s;
  assign reg_write  = rst_n & reg_write_s;
  assign mem_write  = rst_n & mem_write_s;
  assign instr_done = rst_n & instr_done_s;
  assign illegal    = rst_n & illegal_s;
  assign pc_en      = rst_n & (pc_write_s | (branch_s & zero));
  assign state      = state_q;

  alu_decoder #(
    .OP_W   (OP_W),
    .ALUC_W (ALUC_W)
  ) u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// through its state sequence and checks controls against hand-derived values.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, instr_done, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  mips_multicycle_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .iord        (iord),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .pc_en       (pc_en),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag);
    chk({tag, ".state"}, state, FETCH);
    chk({tag, ".ir_write"}, ir_write, 1'b1);
    chk({tag, ".pc_en"}, pc_en, 1'b1);
    chk({tag, ".alu_src_b"}, alu_src_b, 2'b01);
    chk({tag, ".instr_done"}, instr_done, 1'b0);
  endtask

  task automatic chk_decode(input string tag);
    chk({tag, ".state"}, state, DECODE);
    chk({tag, ".alu_src_b"}, alu_src_b, 2'b11);
    chk({tag, ".pc_en"}, pc_en, 1'b0);
    chk({tag, ".ir_write"}, ir_write, 1'b0);
  endtask

  logic [5:0] fn_tab [6];
  logic [2:0] ac_tab [6];

  initial begin
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    ac_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

    rst_n = 1'b0;
    op    = 6'b100011;
    funct = 6'b000000;
    zero  = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst.state", state, FETCH);
      chk("rst.pc_en", pc_en, 1'b0);
      chk("rst.ir_write", ir_write, 1'b0);
      chk("rst.reg_write", reg_write, 1'b0);
      step();
    end
    rst_n = 1'b1;
    #1;
    chk_fetch("rel");

    // lw: 5 cycles
    step(); chk_decode("lw.dec");
    step();
    chk("lw.madr.state", state, MEMADR);
    chk("lw.madr.src_a", alu_src_a, 1'b1);
    chk("lw.madr.src_b", alu_src_b, 2'b10);
    chk("lw.madr.aluc", alu_control, 3'b010);
    step();
    chk("lw.mrd.state", state, MEMRD);
    chk("lw.mrd.iord", iord, 1'b1);
    chk("lw.mrd.reg_write", reg_write, 1'b0);
    step();
    chk("lw.mwb.state", state, MEMWB);
    chk("lw.mwb.reg_write", reg_write, 1'b1);
    chk("lw.mwb.mem_to_reg", mem_to_reg, 1'b1);
    chk("lw.mwb.reg_dst", reg_dst, 1'b0);
    chk("lw.mwb.done", instr_done, 1'b1);
    step(); chk_fetch("lw.end");

    // sw: 4 cycles
    op = 6'b101011;
    step(); chk_decode("sw.dec");
    step(); chk("sw.madr.state", state, MEMADR);
    step();
    chk("sw.mwr.state", state, MEMWR);
    chk("sw.mwr.mem_write", mem_write, 1'b1);
    chk("sw.mwr.iord", iord, 1'b1);
    chk("sw.mwr.done", instr_done, 1'b1);
    chk("sw.mwr.reg_write", reg_write, 1'b0);
    step(); chk_fetch("sw.end");

    // R-type: 4 cycles each, including an unknown funct defaulting to add
    op = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      step(); chk_decode("r.dec");
      step();
      chk("r.ex.state", state, EXECUTE);
      chk("r.ex.aluc", alu_control, ac_tab[i]);
      chk("r.ex.src_a", alu_src_a, 1'b1);
      chk("r.ex.src_b", alu_src_b, 2'b00);
      step();
      chk("r.wb.state", state, ALUWB);
      chk("r.wb.reg_dst", reg_dst, 1'b1);
      chk("r.wb.reg_write", reg_write, 1'b1);
      chk("r.wb.done", instr_done, 1'b1);
      chk("r.wb.illegal", illegal, 1'b0);
      step(); chk_fetch("r.end");
    end

    // beq taken then not taken: 3 cycles each
    op = 6'b000100;
    funct = 6'b100100;
    zero = 1'b1;
    step(); chk_decode("beq1.dec");
    step();
    chk("beq1.state", state, BRANCH);
    chk("beq1.aluc", alu_control, 3'b110);
    chk("beq1.pc_src", pc_src, 2'b01);
    chk("beq1.pc_en", pc_en, 1'b1);
    chk("beq1.done", instr_done, 1'b1);
    zero = 1'b0;
    #1;
    chk("beq1.pc_en_z0", pc_en, 1'b0);
    step(); chk_fetch("beq1.end");
    step(); chk_decode("beq0.dec");
    step();
    chk("beq0.state", state, BRANCH);
    chk("beq0.pc_en", pc_en, 1'b0);
    step(); chk_fetch("beq0.end");

    // j: 3 cycles
    op = 6'b000010;
    step(); chk_decode("j.dec");
    step();
    chk("j.state", state, JUMP);
    chk("j.pc_src", pc_src, 2'b10);
    chk("j.pc_en", pc_en, 1'b1);
    chk("j.done", instr_done, 1'b1);
    step(); chk_fetch("j.end");

    // addi: 4 cycles
    op = 6'b001000;
    step(); chk_decode("addi.dec");
    step();
    chk("addi.ex.state", state, ADDIEX);
    chk("addi.ex.src_b", alu_src_b, 2'b10);
    chk("addi.ex.src_a", alu_src_a, 1'b1);
    chk("addi.ex.aluc", alu_control, 3'b010);
    step();
    chk("addi.wb.state", state, ADDIWB);
    chk("addi.wb.reg_write", reg_write, 1'b1);
    chk("addi.wb.reg_dst", reg_dst, 1'b0);
    chk("addi.wb.mem_to_reg", mem_to_reg, 1'b0);
    chk("addi.wb.done", instr_done, 1'b1);
    step(); chk_fetch("addi.end");

    // illegal opcode: 2 cycles, no instr_done
    op = 6'b111111;
    step();
    chk_decode("ill.dec");
    chk("ill.illegal", illegal, 1'b1);
    chk("ill.done", instr_done, 1'b0);
    step();
    chk_fetch("ill.end");
    chk("ill.end.illegal", illegal, 1'b0);

    // reset during MEMRD of lw aborts the instruction
    op = 6'b100011;
    step(); step(); step();
    chk("mid.mrd.state", state, MEMRD);
    rst_n = 1'b0;
    #1;
    chk("mid.rst.state", state, FETCH);
    chk("mid.rst.reg_write", reg_write, 1'b0);
    chk("mid.rst.pc_en", pc_en, 1'b0);
    chk("mid.rst.ir_write", ir_write, 1'b0);
    step();
    chk("mid.hold.state", state, FETCH);
    chk("mid.hold.reg_write", reg_write, 1'b0);
    rst_n = 1'b1;
    #1;
    chk_fetch("mid.rel");
    step(); chk_decode("mid.dec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main controller for the multicycle MIPS datapath, the successor to the single-cycle core. A Moore FSM sequences one instruction over 3–5 cycles, driving the memory, instruction-register, PC, register-file and ALU mux and enable controls from the latched opcode and funct. It also produces the ALU control code and the gated PC enable. It sits beside the datapath top level and replaces the combinational control unit.

Parameters:
OP_W, 6, opcode and funct field width
ALUC_W, 3, ALU control code width
STATE_W, 4, state register width (12 states used)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  OP_W  Instr[31:26] from the instruction register
funct  in  OP_W  Instr[5:0] from the instruction register
zero  in  1  ALU zero flag
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_write  out  1  data memory write enable
ir_write  out  1  instruction register load
reg_dst  out  1  write register select: 0=rt, 1=rd
mem_to_reg  out  1  write-back select: 0=ALUOut, 1=Data
reg_write  out  1  register file write enable
alu_src_a  out  1  SrcA select: 0=PC, 1=A
alu_src_b  out  2  SrcB select: 00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
pc_src  out  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
pc_en  out  1  PC load = pc_write | (branch & zero)
alu_control  out  ALUC_W  ALU operation code
instr_done  out  1  one-cycle pulse in the final state of each instruction
illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
state  out  STATE_W  current state, for debug

Behaviour:
- rst_n low: state forced to FETCH asynchronously. While rst_n is low, ir_write, pc_en, reg_write, mem_write, instr_done and illegal are forced to 0, and all selects hold their FETCH values. The first FETCH executes on the first rising edge after deassertion.
- All outputs are decoded from the state only (Moore), except pc_en (uses zero) and alu_control (uses funct).
- States and asserted controls (anything not listed is 0, alu_op=00):
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, ir_write=1, pc_write=1. Always goes to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11 (branch target into ALUOut). Next state by op:
    - 100011 or 101011 → MEMADR
    - 000000 → EXECUTE
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - any other → FETCH, with illegal=1
  - MEMADR: alu_src_a=1, alu_src_b=10. lw → MEMRD; sw → MEMWR.
  - MEMRD: iord=1 → MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 → FETCH.
  - MEMWR: iord=1, mem_write=1, instr_done=1 → FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 → ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1 → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1 → FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1 → FETCH.
  - JUMP: pc_src=10, pc_write=1, instr_done=1 → FETCH.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 (no instr_done).
- pc_en equals 1 in FETCH and JUMP. In BRANCH it equals zero. It is 0 everywhere else.
- ALU decode:
  - alu_op=00 → 010 (add)
  - alu_op=01 → 110 (sub)
  - alu_op=10 → decode funct:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111
    - unknown funct → 010 (instruction still completes, no illegal pulse)
- Unreachable state encodings go to FETCH on the next edge with all enables 0.
- Reset asserted mid-instruction aborts it: no partial write-back, state returns to FETCH.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (FETCH…JUMP)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ALU control codes
  - alu_op encoding
- Sub-module alu_decoder: a combinational mapping from alu_op and funct to alu_control, instantiated once.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with op=100011 → state=FETCH, pc_en=0, ir_write=0 throughout. Release → cycle 1 ir_write=1, pc_en=1, alu_src_b=01.
- lw: op=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMRD has iord=1. MEMWB has reg_write=1, mem_to_reg=1, instr_done=1. Next cycle is FETCH.
- R-type: op=000000 with funct sequence 100000, 100010, 100100, 100101, 101010 → alu_control in EXECUTE is 010, 110, 000, 001, 111. ALUWB has reg_dst=1. Each instruction takes 4 cycles.
- beq: op=000100 → BRANCH with alu_control=110, pc_src=01. zero=1 gives pc_en=1; zero=0 gives pc_en=0. Both cases take 3 cycles.
- j and addi: op=000010 → JUMP with pc_src=10, pc_en=1. op=001000 → ADDIEX (alu_src_b=10), then ADDIWB (reg_write=1, reg_dst=0).
- Illegal and mid-op reset: op=111111 → illegal=1 in DECODE, then FETCH, never instr_done. Separately, rst_n drops during MEMRD of lw → no reg_write, state=FETCH immediately.
